// File: rtl/div_mse_monitor.sv
// Error-statistics monitor for the 16/8 array divider. It takes each operand pair and the
// quotient/remainder the array produced, recomputes the exact result with an 8-step restoring
// divider, and accumulates saturating squared errors, sample counts and the peak quotient error.
module div_mse_monitor #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      n,
  input  logic [7:0]       d,
  input  logic [7:0]       q_apx,
  input  logic [7:0]       r_apx,
  input  logic             clr,
  output logic             busy,
  output logic [ACC_W-1:0] sum_sq_q,
  output logic [ACC_W-1:0] sum_sq_r,
  output logic [7:0]       max_abs_q,
  output logic [CNT_W-1:0] n_valid,
  output logic [CNT_W-1:0] n_skip,
  output logic             err_flag
);

  typedef enum logic [1:0] {StIdle, StDiv, StAcc} state_e;

  state_e           state_q, state_d;
  logic [7:0]       d_q, d_d;
  logic [7:0]       qa_q, qa_d;
  logic [7:0]       ra_q, ra_d;
  logic [7:0]       lo_q, lo_d;     // dividend low byte, consumed MSB first
  logic [2:0]       step_q, step_d;
  logic [7:0]       rem_q, rem_d;   // partial remainder, always below d
  logic [7:0]       quo_q, quo_d;
  logic [ACC_W-1:0] ssq_q, ssq_d;
  logic [ACC_W-1:0] ssr_q, ssr_d;
  logic [7:0]       maxq_q, maxq_d;
  logic [CNT_W-1:0] nval_q, nval_d;
  logic [CNT_W-1:0] nskip_q, nskip_d;
  logic             err_q, err_d;

  // Restoring step datapath: shift in next dividend bit, trial-subtract at 9-bit width.
  logic [8:0] rem_sh;
  logic [9:0] trial;
  logic       borrow;
  logic       unused_trial;

  assign rem_sh       = {rem_q, lo_q[7]};
  assign trial        = {1'b0, rem_sh} - {2'b00, d_q};
  assign borrow       = trial[9];
  assign unused_trial = trial[8];

  // Error terms; squaring the magnitudes keeps the multiply unsigned.
  logic [8:0]       eq, er;
  logic [7:0]       abs_eq, abs_er;
  logic [15:0]      sq_eq, sq_er;
  logic [ACC_W:0]   add_q, add_r;

  assign eq     = {1'b0, qa_q} - {1'b0, quo_q};
  assign er     = {1'b0, ra_q} - {1'b0, rem_q};
  assign abs_eq = eq[8] ? (8'd0 - eq[7:0]) : eq[7:0];
  assign abs_er = er[8] ? (8'd0 - er[7:0]) : er[7:0];
  assign sq_eq  = 16'(abs_eq) * 16'(abs_eq);
  assign sq_er  = 16'(abs_er) * 16'(abs_er);
  assign add_q  = {1'b0, ssq_q} + (ACC_W + 1)'(sq_eq);
  assign add_r  = {1'b0, ssr_q} + (ACC_W + 1)'(sq_er);

  logic is_skip;
  assign is_skip = (d == 8'd0) || (n[15:8] >= d);

  // Next-state: clear, accept/skip, restoring steps and statistics update.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    qa_d    = qa_q;
    ra_d    = ra_q;
    lo_d    = lo_q;
    step_d  = step_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    ssq_d   = ssq_q;
    ssr_d   = ssr_q;
    maxq_d  = maxq_q;
    nval_d  = nval_q;
    nskip_d = nskip_q;
    err_d   = err_q;

    if (clr) begin
      // Abort any in-flight sample and discard it.
      state_d = StIdle;
      ssq_d   = '0;
      ssr_d   = '0;
      maxq_d  = '0;
      nval_d  = '0;
      nskip_d = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            d_d  = d;
            qa_d = q_apx;
            ra_d = r_apx;
            lo_d = n[7:0];
            if (is_skip) begin
              nskip_d = (nskip_q == '1) ? nskip_q : nskip_q + CNT_W'(1);
            end else begin
              state_d = StDiv;
              step_d  = 3'd0;
              rem_d   = n[15:8];
              quo_d   = 8'd0;
            end
          end
        end
        StDiv: begin
          rem_d  = borrow ? rem_sh[7:0] : trial[7:0];
          quo_d  = {quo_q[6:0], ~borrow};
          lo_d   = {lo_q[6:0], 1'b0};
          step_d = step_q + 3'd1;
          if (step_q == 3'd7) begin
            state_d = StAcc;
          end
        end
        StAcc: begin
          ssq_d   = add_q[ACC_W] ? '1 : add_q[ACC_W-1:0];
          ssr_d   = add_r[ACC_W] ? '1 : add_r[ACC_W-1:0];
          nval_d  = (nval_q == '1) ? nval_q : nval_q + CNT_W'(1);
          maxq_d  = (abs_eq > maxq_q) ? abs_eq : maxq_q;
          err_d   = err_q | (eq != 9'd0) | (er != 9'd0);
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      d_q     <= '0;
      qa_q    <= '0;
      ra_q    <= '0;
      lo_q    <= '0;
      step_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      ssq_q   <= '0;
      ssr_q   <= '0;
      maxq_q  <= '0;
      nval_q  <= '0;
      nskip_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      qa_q    <= qa_d;
      ra_q    <= ra_d;
      lo_q    <= lo_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      ssq_q   <= ssq_d;
      ssr_q   <= ssr_d;
      maxq_q  <= maxq_d;
      nval_q  <= nval_d;
      nskip_q <= nskip_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign sum_sq_q  = ssq_q;
  assign sum_sq_r  = ssr_q;
  assign max_abs_q = maxq_q;
  assign n_valid   = nval_q;
  assign n_skip    = nskip_q;
  assign err_flag  = err_q;

endmodule

// File: tb/tb_div_mse_monitor.sv
// Scoreboard bench for div_mse_monitor. The driver predicts each sample's effect from plain
// division and pushes the expected statistics with the edge they must appear on; a monitor
// process pops and compares on falling edges. A second instance with ACC_W=17 exercises
// accumulator saturation on the same stimulus.
module tb_div_mse_monitor;

  logic        clk = 1'b0;
  logic        rst, in_valid, clr;
  logic [15:0] n;
  logic [7:0]  d, q_apx, r_apx;

  logic        in_ready, busy, err_flag;
  logic [39:0] sum_sq_q, sum_sq_r;
  logic [7:0]  max_abs_q;
  logic [23:0] n_valid, n_skip;

  logic        in_ready_s, busy_s, err_flag_s;
  logic [16:0] sum_sq_q_s, sum_sq_r_s;
  logic [7:0]  max_abs_q_s;
  logic [23:0] n_valid_s, n_skip_s;

  div_mse_monitor #(.ACC_W(40), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .n(n), .d(d),
    .q_apx(q_apx), .r_apx(r_apx), .clr(clr), .busy(busy), .sum_sq_q(sum_sq_q),
    .sum_sq_r(sum_sq_r), .max_abs_q(max_abs_q), .n_valid(n_valid), .n_skip(n_skip),
    .err_flag(err_flag)
  );

  div_mse_monitor #(.ACC_W(17), .CNT_W(24)) dut17 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .n(n), .d(d),
    .q_apx(q_apx), .r_apx(r_apx), .clr(clr), .busy(busy_s), .sum_sq_q(sum_sq_q_s),
    .sum_sq_r(sum_sq_r_s), .max_abs_q(max_abs_q_s), .n_valid(n_valid_s), .n_skip(n_skip_s),
    .err_flag(err_flag_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     due;
    longint sq40, sr40, sq17, sr17;
    int     maxq;
    longint nv, ns;
    bit     err;
  } exp_t;

  exp_t   sbq[$];
  exp_t   cur;
  exp_t   mdl;
  int     edge_n = 0;
  int     free_edge = 0;   // first edge at which a new sample can be accepted
  int     checks = 0;
  int     errors = 0;
  bit     mon_on = 1'b0;

  function automatic longint sat_add(input longint a, input longint b, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (a + b > m) ? m : a + b;
  endfunction

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  // Present a sample, hold it until the predicted accept edge, then record its effect.
  task automatic send(input logic [15:0] nn, input logic [7:0] dd, input logic [7:0] qa,
                      input logic [7:0] ra);
    int acc_edge, q_ex, r_ex, eq, er;
    n = nn; d = dd; q_apx = qa; r_apx = ra; in_valid = 1'b1;
    acc_edge = (edge_n + 1 > free_edge) ? edge_n + 1 : free_edge;
    while (edge_n < acc_edge) begin
      @(posedge clk); #1;
    end
    if (dd == 0 || (int'(nn) / int'(dd)) > 255) begin
      mdl.ns  = sat_add(mdl.ns, 1, 24);
      mdl.due = acc_edge;
      free_edge = acc_edge + 1;
    end else begin
      q_ex = int'(nn) / int'(dd);
      r_ex = int'(nn) % int'(dd);
      eq = int'(qa) - q_ex;
      er = int'(ra) - r_ex;
      mdl.sq40 = sat_add(mdl.sq40, longint'(eq * eq), 40);
      mdl.sr40 = sat_add(mdl.sr40, longint'(er * er), 40);
      mdl.sq17 = sat_add(mdl.sq17, longint'(eq * eq), 17);
      mdl.sr17 = sat_add(mdl.sr17, longint'(er * er), 17);
      mdl.nv   = sat_add(mdl.nv, 1, 24);
      if ((eq < 0 ? -eq : eq) > mdl.maxq) mdl.maxq = (eq < 0) ? -eq : eq;
      if (eq != 0 || er != 0) mdl.err = 1'b1;
      mdl.due = acc_edge + 9;
      free_edge = acc_edge + 10;
    end
    sbq.push_back(mdl);
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  // One-edge clr (or rst): everything not yet reported at that edge is dropped.
  task automatic clear(input bit use_rst);
    int c;
    in_valid = 1'b0;
    if (use_rst) rst = 1'b1;
    else clr = 1'b1;
    c = edge_n + 1;
    while (sbq.size() > 0 && sbq[$].due >= c) void'(sbq.pop_back());
    mdl = '{default: 0};
    mdl.due = c;
    sbq.push_back(mdl);
    if (free_edge > c + 1) free_edge = c + 1;
    @(posedge clk); #1;
    rst = 1'b0;
    clr = 1'b0;
  endtask

  task automatic rand_sample();
    logic [7:0] dd, hi, lo, qa, ra;
    int qe, re;
    dd = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    hi = 8'($urandom_range(0, 255));
    if (dd != 0 && $urandom_range(0, 3) != 0) hi = hi % dd;
    lo = 8'($urandom);
    qe = 0; re = 0;
    if (dd != 0) begin
      qe = int'({hi, lo}) / int'(dd);
      re = int'({hi, lo}) % int'(dd);
    end
    case ($urandom_range(0, 2))
      0: begin qa = 8'(qe); ra = 8'(re); end
      1: begin
        qa = 8'(qe + int'($urandom_range(0, 6)) - 3);
        ra = 8'(re + int'($urandom_range(0, 4)) - 2);
      end
      default: begin qa = 8'($urandom); ra = 8'($urandom); end
    endcase
    send({hi, lo}, dd, qa, ra);
    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
  endtask

  // Monitor: adopt every expectation whose edge has passed, then compare both instances.
  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      bit exp_ready;
      while (sbq.size() > 0 && sbq[0].due <= edge_n) cur = sbq.pop_front();
      exp_ready = (edge_n + 1 >= free_edge);
      checks++;
      if (in_ready !== exp_ready || busy !== !exp_ready || in_ready_s !== exp_ready ||
          busy_s !== !exp_ready) begin
        errors++;
        $display("FAIL handshake edge=%0d in_ready=%b busy=%b ready17=%b want in_ready=%b",
                 edge_n, in_ready, busy, in_ready_s, exp_ready);
      end
      checks++;
      if (sum_sq_q !== 40'(cur.sq40) || sum_sq_r !== 40'(cur.sr40) ||
          max_abs_q !== 8'(cur.maxq) || n_valid !== 24'(cur.nv) ||
          n_skip !== 24'(cur.ns) || err_flag !== cur.err ||
          sum_sq_q_s !== 17'(cur.sq17) || sum_sq_r_s !== 17'(cur.sr17) ||
          max_abs_q_s !== 8'(cur.maxq) || n_valid_s !== 24'(cur.nv) ||
          n_skip_s !== 24'(cur.ns) || err_flag_s !== cur.err) begin
        errors++;
        $display({"FAIL stats edge=%0d got sq=%0d sr=%0d max=%0d nv=%0d ns=%0d err=%b ",
                  "sq17=%0d sr17=%0d want sq=%0d sr=%0d max=%0d nv=%0d ns=%0d err=%b ",
                  "sq17=%0d sr17=%0d"},
                 edge_n, sum_sq_q, sum_sq_r, max_abs_q, n_valid, n_skip, err_flag,
                 sum_sq_q_s, sum_sq_r_s, cur.sq40, cur.sr40, cur.maxq, cur.nv, cur.ns,
                 cur.err, cur.sq17, cur.sr17);
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
    n = '0; d = '0; q_apx = '0; r_apx = '0;
    mdl = '{default: 0};
    cur = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_on = 1'b1;
    idle(2);

    // Exact match, then an approximate result with q error -2 and r error +3.
    send(16'd1000, 8'd7, 8'd142, 8'd6);
    idle(1);
    send(16'd1000, 8'd7, 8'd140, 8'd9);
    idle(2);

    // Skips: divide by zero, then quotient overflow, back to back.
    send(16'h1234, 8'd0, 8'd5, 8'd5);
    send(16'h0800, 8'd8, 8'd0, 8'd0);
    idle(2);

    // Three samples with in_valid held high throughout.
    send(16'd5000, 8'd40, 8'd125, 8'd0);
    send(16'd777, 8'd13, 8'd60, 8'd0);
    send(16'd65000, 8'd255, 8'd250, 8'd3);
    idle(12);

    // clr four cycles into a division, then a normal sample.
    send(16'd900, 8'd9, 8'd99, 8'd1);
    idle(3);
    clear(1'b0);
    send(16'd300, 8'd7, 8'd42, 8'd5);
    idle(12);

    // Quotient error of 255 repeatedly: the 17-bit accumulator saturates.
    clear(1'b0);
    repeat (4) send(16'h00FF, 8'd1, 8'd0, 8'd0);
    idle(12);

    // Randomized samples with mixed gaps and held-valid bursts.
    clear(1'b0);
    for (int i = 0; i < 40; i++) rand_sample();
    idle(12);

    // Reset in the middle of a division.
    send(16'd1000, 8'd7, 8'd1, 8'd1);
    idle(5);
    clear(1'b1);
    idle(12);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sbq.size());
    end
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
